// File: rtl/vga_scanout_pkg.sv
// Shared definitions for the VGA scan-out block: 640x480@60 timing defaults,
// total-period derivation and VRAM-pixel to RGB444 expansion.
package vga_scanout_pkg;

   localparam int DEF_H_ACTIVE = 32'sd640;
   localparam int DEF_H_FP     = 32'sd16;
   localparam int DEF_H_SYNC   = 32'sd96;
   localparam int DEF_H_BP     = 32'sd48;
   localparam int DEF_V_ACTIVE = 32'sd480;
   localparam int DEF_V_FP     = 32'sd10;
   localparam int DEF_V_SYNC   = 32'sd2;
   localparam int DEF_V_BP     = 32'sd33;

   // Full period of one axis: visible + front porch + sync + back porch.
   function automatic int calc_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   // Expand a packed VRAM pixel (zero-extended to 12 bits) into {R,G,B} nibbles.
   function automatic logic [11:0] expand_rgb444(input logic [11:0] data, input int bpp);
      logic [11:0] rgb;
      rgb = 12'h000;
      case (bpp)
         32'sd3:  rgb = {{4{data[2]}}, {4{data[1]}}, {4{data[0]}}};
         32'sd6:  rgb = {{2{data[5:4]}}, {2{data[3:2]}}, {2{data[1:0]}}};
         32'sd12: rgb = data;
         default: rgb = 12'h000;
      endcase
      return rgb;
   endfunction

endpackage

// File: rtl/vga_scanout_timing.sv
// Raster timing for vga_scanout: horizontal/vertical counters, active-area,
// sync and vblank decode, plus the strobes that pace the VRAM pointer.
// Build option: VGA_SCANOUT_DOUBLE_EN selects 2x2 pixel replication cadence.
module vga_timing
   import vga_scanout_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int HW       = 32'sd10,
   parameter int VW       = 32'sd10
) (
   input  logic clk,
   input  logic reset,
   output logic active,
   output logic hsync,
   output logic vsync,
   output logic vblank,
   output logic vblank_start,
   output logic frame_start,
   output logic frame_end,
   output logic ptr_step,
   output logic ptr_rewind,
   output logic ptr_save
);

   localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   logic [HW-1:0] hcnt_r;
   logic [VW-1:0] vcnt_r;
   logic          h_last_s;
   logic          v_last_s;
   logic          line_end_s;

   // Raster position: hcnt wraps every line, vcnt steps on each hcnt wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt_r <= '0;
         vcnt_r <= '0;
      end else if (h_last_s) begin
         hcnt_r <= '0;
         if (v_last_s) begin
            vcnt_r <= '0;
         end else begin
            vcnt_r <= vcnt_r + VW'(1);
         end
      end else begin
         hcnt_r <= hcnt_r + HW'(1);
      end
   end

   // Decode region, sync windows, frame markers and pointer pacing from the counters.
   always_comb begin
      h_last_s     = (hcnt_r == HW'(H_TOTAL - 1));
      v_last_s     = (vcnt_r == VW'(V_TOTAL - 1));
      active       = (hcnt_r < HW'(H_ACTIVE)) && (vcnt_r < VW'(V_ACTIVE));
      line_end_s   = (hcnt_r == HW'(H_ACTIVE - 1));
      hsync        = (hcnt_r >= HW'(H_ACTIVE + H_FP)) && (hcnt_r < HW'(H_ACTIVE + H_FP + H_SYNC));
      vsync        = (vcnt_r >= VW'(V_ACTIVE + V_FP)) && (vcnt_r < VW'(V_ACTIVE + V_FP + V_SYNC));
      vblank       = (vcnt_r >= VW'(V_ACTIVE));
      vblank_start = (hcnt_r == '0) && (vcnt_r == VW'(V_ACTIVE));
      frame_start  = (hcnt_r == '0) && (vcnt_r == '0);
      frame_end    = h_last_s && v_last_s;
`ifdef VGA_SCANOUT_DOUBLE_EN
      // Step on odd pixels; an even line rewinds to its base so the next
      // display line repeats it, an odd line moves the base forward.
      ptr_rewind   = active && line_end_s && !vcnt_r[0];
      ptr_save     = active && line_end_s && vcnt_r[0];
      ptr_step     = active && hcnt_r[0] && !ptr_rewind;
`else
      ptr_rewind   = 1'b0;
      ptr_save     = 1'b0;
      ptr_step     = active && (line_end_s || !line_end_s);
`endif
   end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out top: VRAM address pointer, per-frame enable latch, the
// two-stage address->data->colour pipeline and colour expansion.
// Build option: VGA_SCANOUT_DOUBLE_EN shows each VRAM pixel as 2x2 display pixels.
module vga_scanout
   import vga_scanout_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter int   BPP      = 32'sd3,
   parameter int   ADDR_W   = 32'sd16,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic              CLK,
   input  logic              I_RESET,
   input  logic              I_ENABLE,
   output logic [ADDR_W-1:0] O_VRAM_ADDR,
   input  logic [BPP-1:0]    I_VRAM_DATA,
   output logic              O_HSYNC,
   output logic              O_VSYNC,
   output logic [3:0]        O_VIDEO_R,
   output logic [3:0]        O_VIDEO_G,
   output logic [3:0]        O_VIDEO_B,
   output logic              O_VBLANK,
   output logic              O_VBLANK_START
);

   localparam int HW = $clog2(calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
   localparam int VW = $clog2(calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

   logic              active_s;
   logic              hsync_s;
   logic              vsync_s;
   logic              vblank_s;
   logic              vblank_start_s;
   logic              frame_start_s;
   logic              frame_end_s;
   logic              ptr_step_s;
   logic              ptr_rewind_s;
   logic              ptr_save_s;

   logic [ADDR_W-1:0] ptr_r;
   logic [ADDR_W-1:0] base_r;
   logic              en_r;
   logic              en_frame_s;

   logic              vis1_r;
   logic              hs1_r;
   logic              vs1_r;
   logic              vb1_r;
   logic              vbs1_r;
   logic              hs2_r;
   logic              vs2_r;
   logic              vb2_r;
   logic              vbs2_r;
   logic [11:0]       rgb_s;
   logic [11:0]       rgb_r;

   vga_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HW(HW), .VW(VW)
   ) u_timing (
      .clk          (CLK),
      .reset        (I_RESET),
      .active       (active_s),
      .hsync        (hsync_s),
      .vsync        (vsync_s),
      .vblank       (vblank_s),
      .vblank_start (vblank_start_s),
      .frame_start  (frame_start_s),
      .frame_end    (frame_end_s),
      .ptr_step     (ptr_step_s),
      .ptr_rewind   (ptr_rewind_s),
      .ptr_save     (ptr_save_s)
   );

   // VRAM pointer: cleared for the next frame, otherwise rewound or stepped;
   // natural ADDR_W overflow gives the modulo wrap.
   always_ff @(posedge CLK) begin
      if (I_RESET) begin
         ptr_r  <= '0;
         base_r <= '0;
      end else if (frame_end_s) begin
         ptr_r  <= '0;
         base_r <= '0;
      end else if (ptr_rewind_s) begin
         ptr_r  <= base_r;
      end else if (ptr_step_s) begin
         ptr_r  <= ptr_r + ADDR_W'(1);
         if (ptr_save_s) begin
            base_r <= ptr_r + ADDR_W'(1);
         end
      end
   end

   // Enable in force this clock: I_ENABLE on the first clock of a frame, else the latched value.
   always_comb begin
      if (frame_start_s) begin
         en_frame_s = I_ENABLE;
      end else begin
         en_frame_s = en_r;
      end
   end

   // Hold the frame's enable decision until the next frame start.
   always_ff @(posedge CLK) begin
      if (I_RESET) begin
         en_r <= 1'b0;
      end else begin
         en_r <= en_frame_s;
      end
   end

   // Colour for the pixel whose data is arriving now; black when blanked or disabled.
   always_comb begin
      if (vis1_r) begin
         rgb_s = expand_rgb444(12'(I_VRAM_DATA), BPP);
      end else begin
         rgb_s = 12'h000;
      end
   end

   // Two-stage delay line keeping syncs/blanking aligned with registered colour.
   always_ff @(posedge CLK) begin
      if (I_RESET) begin
         vis1_r <= 1'b0;
         hs1_r  <= ~HS_POL;
         vs1_r  <= ~VS_POL;
         vb1_r  <= 1'b0;
         vbs1_r <= 1'b0;
         hs2_r  <= ~HS_POL;
         vs2_r  <= ~VS_POL;
         vb2_r  <= 1'b0;
         vbs2_r <= 1'b0;
         rgb_r  <= 12'h000;
      end else begin
         vis1_r <= active_s && en_frame_s;
         hs1_r  <= hsync_s ? HS_POL : ~HS_POL;
         vs1_r  <= vsync_s ? VS_POL : ~VS_POL;
         vb1_r  <= vblank_s;
         vbs1_r <= vblank_start_s;
         hs2_r  <= hs1_r;
         vs2_r  <= vs1_r;
         vb2_r  <= vb1_r;
         vbs2_r <= vbs1_r;
         rgb_r  <= rgb_s;
      end
   end

   assign O_VRAM_ADDR    = ptr_r;
   assign O_HSYNC        = hs2_r;
   assign O_VSYNC        = vs2_r;
   assign O_VBLANK       = vb2_r;
   assign O_VBLANK_START = vbs2_r;
   assign O_VIDEO_R      = rgb_r[11:8];
   assign O_VIDEO_G      = rgb_r[7:4];
   assign O_VIDEO_B      = rgb_r[3:0];

endmodule
